// File: rtl/gb_pkg.sv
// Shared definitions for the ghostbus host bridge: FSM encoding and default bus widths.
package gb_pkg;

  localparam int GB_AW = 12;
  localparam int GB_DW = 32;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } gb_state_e;

endpackage

// File: rtl/gb_host_bridge_if.sv
// Host request/response streams plus the ghostbus master signals of the bridge.
interface gb_host_bridge_if #(
  parameter int AW = gb_pkg::GB_AW,
  parameter int DW = gb_pkg::GB_DW
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_dout;
  logic [DW-1:0] gb_din;
  logic          gb_we;
  logic          busy;

  // Host side (and the decoded hierarchy returning gb_din)
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, gb_din,
    input  req_ready, rsp_valid, rsp_rdata, gb_addr, gb_dout, gb_we, busy
  );

  // Bridge side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, gb_din,
    output req_ready, rsp_valid, rsp_rdata, gb_addr, gb_dout, gb_we, busy
  );

endinterface

// File: rtl/gb_resp_fifo.sv
// First-word-fall-through response FIFO with occupancy count; storage is not reset,
// only the pointers and count are.
module gb_resp_fifo #(
  parameter int DW = 32,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (count_r == '0);
  assign do_push_s = push && (count_r != DEPTH_C);
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/gb_host_bridge.sv
// Ghostbus host master: turns request beats into registered gb_addr/gb_dout/gb_we cycles,
// waits out the leaf read latency and queues read data into a FWFT response FIFO.
module gb_host_bridge import gb_pkg::*; #(
  parameter int AW      = GB_AW,
  parameter int DW      = GB_DW,
  parameter int RD_LAT  = 1,
  parameter int FIFO_AW = 2
) (
  input  logic            gb_clk,
  input  logic            gb_rst,
  gb_host_bridge_if.slave bus
);

  localparam int CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(2**FIFO_AW);

  gb_state_e      state_r;
  gb_state_e      state_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_s;
  logic [AW-1:0]  gb_addr_r;
  logic [DW-1:0]  gb_dout_r;
  logic           gb_we_r;
  logic           ready_s;
  logic           wr_accept_s;
  logic           rd_accept_s;
  logic           push_s;
  logic           pop_s;
  logic           fifo_empty_s;
  logic [FIFO_AW:0] fifo_count_s;
  logic [DW-1:0]  fifo_head_s;

  // Accepting only while a FIFO slot is free guarantees room for the read this beat may be.
  assign ready_s     = (state_r == ST_IDLE) && (fifo_count_s < DEPTH_C) && !gb_rst;
  assign wr_accept_s = bus.req_valid && ready_s && bus.req_we;
  assign rd_accept_s = bus.req_valid && ready_s && !bus.req_we;
  assign pop_s       = bus.rsp_ready && !fifo_empty_s;

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = !fifo_empty_s;
  assign bus.rsp_rdata = fifo_head_s;
  assign bus.gb_addr   = gb_addr_r;
  assign bus.gb_dout   = gb_dout_r;
  assign bus.gb_we     = gb_we_r;
  assign bus.busy      = (state_r != ST_IDLE) || (fifo_count_s != '0);

  // Next-state logic: a read counts down RD_LAT edges, then samples gb_din on the next one.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    push_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_accept_s) begin
          state_s = ST_RD_WAIT;
          cnt_s   = CW'(RD_LAT);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_r == '0) begin
          push_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, wait counter and registered ghostbus outputs; gb_addr holds through RD_WAIT.
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      gb_addr_r <= '0;
      gb_dout_r <= '0;
      gb_we_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      gb_we_r <= wr_accept_s;
      if (wr_accept_s || rd_accept_s) begin
        gb_addr_r <= bus.req_addr;
      end
      if (wr_accept_s) begin
        gb_dout_r <= bus.req_wdata;
      end
    end
  end

  gb_resp_fifo #(
    .DW (DW),
    .AW (FIFO_AW)
  ) u_resp_fifo (
    .clk   (gb_clk),
    .rst   (gb_rst),
    .push  (push_s),
    .din   (bus.gb_din),
    .pop   (pop_s),
    .dout  (fifo_head_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

endmodule

// File: tb/tb_gb_host_bridge.sv
// Directed bench for gb_host_bridge: RD_LAT=1 instance with a register-backed leaf model,
// plus an RD_LAT=3 instance whose gb_din is driven cycle by cycle.
module tb_gb_host_bridge;
  import gb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gb_host_bridge_if #(.AW(12), .DW(32)) bus ();
  gb_host_bridge_if #(.AW(12), .DW(32)) bus3 ();

  gb_host_bridge #(.AW(12), .DW(32), .RD_LAT(1), .FIFO_AW(2)) u_dut (
    .gb_clk (clk),
    .gb_rst (rst),
    .bus    (bus)
  );

  gb_host_bridge #(.AW(12), .DW(32), .RD_LAT(3), .FIFO_AW(2)) u_dut3 (
    .gb_clk (clk),
    .gb_rst (rst),
    .bus    (bus3)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int we_viol = 0;

  // Leaf model: one read register; unwritten locations return a fixed pattern
  logic [31:0] mem [0:4095];
  bit          mem_valid [0:4095];

  function automatic logic [31:0] model_default(input logic [11:0] a);
    if (a == 12'h040) return 32'h0000_00A5;
    return {20'h00001, a};
  endfunction

  always @(posedge clk) begin
    if (bus.gb_we === 1'b1) begin
      mem[bus.gb_addr]       <= bus.gb_dout;
      mem_valid[bus.gb_addr] <= 1'b1;
    end
    bus.gb_din <= mem_valid[bus.gb_addr] ? mem[bus.gb_addr] : model_default(bus.gb_addr);
  end

  always @(negedge clk) begin
    if (bus.gb_we === 1'b1 && bus.busy === 1'b1 && bus.req_ready === 1'b0) we_viol++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, want);
  endtask

  // Present one beat and return at the negedge just after the accepting edge
  task automatic send(input logic we, input logic [11:0] addr, input logic [31:0] wd);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("req_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string name, input logic [31:0] want);
    int n;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    chk(name, bus.rsp_rdata, want);
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] din_seq [4];
  int          cnt_a;
  int          cnt_b;

  initial begin
    vecs[0] = '{1'b1, 12'h000, 32'h0000_0042};
    vecs[1] = '{1'b0, 12'h000, 32'h0000_0042};
    vecs[2] = '{1'b1, 12'h200, 32'h0000_0001};
    vecs[3] = '{1'b0, 12'h200, 32'h0000_0001};
    vecs[4] = '{1'b1, 12'h400, 32'h0000_0002};
    vecs[5] = '{1'b0, 12'h400, 32'h0000_0002};
    vecs[6] = '{1'b0, 12'h040, 32'h0000_00A5};
    vecs[7] = '{1'b1, 12'hFFF, 32'hDEAD_BEEF};
    vecs[8] = '{1'b0, 12'hFFF, 32'hDEAD_BEEF};
    din_seq[0] = 32'h11; din_seq[1] = 32'h22; din_seq[2] = 32'h33; din_seq[3] = 32'h44;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 12'h0; bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = 12'h0; bus3.req_wdata = 32'h0;
    bus3.rsp_ready = 1'b0; bus3.gb_din = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_gb_addr", {20'd0, bus.gb_addr}, 32'd0);
    chk("rst_gb_dout", bus.gb_dout, 32'd0);
    chk("rst_gb_we", {31'd0, bus.gb_we}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Table: alternating writes and reads, back-to-back
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].we ? vecs[i].data : 32'h0);
      if (vecs[i].we) begin
        chk($sformatf("v%0d_we_pulse", i), {31'd0, bus.gb_we}, 32'd1);
        chk($sformatf("v%0d_gb_addr", i), {20'd0, bus.gb_addr}, {20'd0, vecs[i].addr});
        chk($sformatf("v%0d_gb_dout", i), bus.gb_dout, vecs[i].data);
        chk($sformatf("v%0d_no_rsp", i), {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_we_end", i), {31'd0, bus.gb_we}, 32'd0);
        chk($sformatf("v%0d_dout_held", i), bus.gb_dout, vecs[i].data);
      end else begin
        get_rsp($sformatf("v%0d_rdata", i), vecs[i].data);
      end
    end
    chk("we_in_rdwait", we_viol, 32'd0);

    // Read timing: address held and req_ready low for two cycles
    send(1'b0, 12'h040, 32'h0);
    chk("rd_addr_c0", {20'd0, bus.gb_addr}, 32'h040);
    chk("rd_ready_c0", {31'd0, bus.req_ready}, 32'd0);
    chk("rd_busy_c0", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("rd_addr_c1", {20'd0, bus.gb_addr}, 32'h040);
    chk("rd_ready_c1", {31'd0, bus.req_ready}, 32'd0);
    chk("rd_rsp_c1", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rd_rsp_c2", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rd_data_c2", bus.rsp_rdata, 32'hA5);
    chk("rd_ready_c2", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    chk("rd_popped", {31'd0, bus.rsp_valid}, 32'd0);

    // Fill the FIFO with rsp_ready low
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 12'h100 + 12'(i), 32'h0);
    repeat (3) @(negedge clk);
    chk("full_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("full_head", bus.rsp_rdata, 32'h0000_1100);
    chk("full_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("full_busy", {31'd0, bus.busy}, 32'd1);
    cnt_a = 0;
    cnt_b = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h104;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.req_ready !== 1'b0) cnt_a++;
    end
    bus.req_we = 1'b1; bus.req_addr = 12'h300; bus.req_wdata = 32'h77;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.req_ready !== 1'b0) cnt_a++;
      if (bus.gb_we !== 1'b0) cnt_b++;
    end
    bus.req_valid = 1'b0;
    chk("full_ready_stuck_low", cnt_a, 32'd0);
    chk("full_write_blocked", cnt_b, 32'd0);
    chk("full_head_kept", bus.rsp_rdata, 32'h0000_1100);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) get_rsp($sformatf("drain%0d", i), 32'h0000_1100 + 32'(i));
    chk("drain_empty", {31'd0, bus.rsp_valid}, 32'd0);
    chk("drain_ready", {31'd0, bus.req_ready}, 32'd1);
    send(1'b0, 12'h104, 32'h0);
    get_rsp("after_drain_rd4", 32'h0000_1104);
    send(1'b0, 12'h105, 32'h0);
    get_rsp("after_drain_rd5", 32'h0000_1105);

    // Reset in the middle of RD_WAIT drops the read
    send(1'b0, 12'h040, 32'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_gb_addr", {20'd0, bus.gb_addr}, 32'd0);
    chk("mid_rst_gb_we", {31'd0, bus.gb_we}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt_a = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) cnt_a++;
    end
    chk("mid_rst_no_rsp", cnt_a, 32'd0);
    send(1'b0, 12'h000, 32'h0);
    get_rsp("post_rst_rd", 32'h0000_0042);

    // RD_LAT=3 instance: capture on the fourth edge after accept
    bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.req_addr = 12'h123;
    chk("l3_ready", {31'd0, bus3.req_ready}, 32'd1);
    @(negedge clk);
    bus3.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus3.gb_din = din_seq[k];
      chk($sformatf("l3_addr_c%0d", k), {20'd0, bus3.gb_addr}, 32'h123);
      chk($sformatf("l3_no_rsp_c%0d", k), {31'd0, bus3.rsp_valid}, 32'd0);
      chk($sformatf("l3_ready_c%0d", k), {31'd0, bus3.req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("l3_rsp_valid", {31'd0, bus3.rsp_valid}, 32'd1);
    chk("l3_rdata", bus3.rsp_rdata, 32'h44);
    bus3.gb_din = 32'h55;
    @(negedge clk);
    chk("l3_rdata_stable", bus3.rsp_rdata, 32'h44);
    bus3.rsp_ready = 1'b1;
    @(negedge clk);
    chk("l3_drained", {31'd0, bus3.rsp_valid}, 32'd0);
    chk("l3_idle", {31'd0, bus3.busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
